alu_mul_sequencer: RTL and testbench

//  Multi-cycle unsigned shift-add multiplier controller that time-shares the N-bit ALU.
//  - Issues one ALU addition per cycle for N cycles and accumulates a 2N-bit product.
//  - Start/busy/done handshake toward the datapath control unit.
//  - Drives all ALU control inputs; the ALU itself stays outside this block.

---
 rtl/alu_mul_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// ----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Purpose:
//   Multi-cycle unsigned shift-add multiplier controller that borrows an
//   external N-bit ALU. Once a start is accepted it issues one ALU addition
//   per cycle for N cycles. Each addition folds the multiplicand into the
//   high half of a 2N-bit {HI,LO} accumulator. A one-cycle done pulse then
//   marks the product as ready.
//
// Ports:
//   clk_i            in   1    clock, rising edge
//   rst_i            in   1    synchronous active-high reset
//   start_i          in   1    request, sampled only while idle
//   multiplicand_i   in   N    operand M, captured on accepted start
//   multiplier_i     in   N    operand Q, captured on accepted start
//   busy_o           out  1    high while calculating and during done
//   done_o           out  1    one-cycle completion pulse
//   product_o        out  2N   {HI,LO}, valid from done until next start
//   alu_a_o          out  N    ALU operand a (always HI)
//   alu_b_o          out  N    ALU operand b (M or zero)
//   alu_c_o          out  1    ALU carry-in (always 0)
//   alu_invert_o     out  1    ALU invert control (always 0)
//   alu_less_o       out  1    ALU less input (always 0)
//   alu_operacion_o  out  3    ALU operation select (always OP_ADD)
//   alu_resultado_i  in   N    ALU sum, combinational
//   alu_c_i          in   1    ALU carry-out, combinational
// ----------------------------------------------------------------------------
module alu_mul_sequencer #(
  parameter int          N      = 32,
  parameter logic [2:0]  OP_ADD = 3'b010
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [N-1:0]   multiplicand_i,
  input  logic [N-1:0]   multiplier_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] product_o,
  output logic [N-1:0]   alu_a_o,
  output logic [N-1:0]   alu_b_o,
  output logic           alu_c_o,
  output logic           alu_invert_o,
  output logic           alu_less_o,
  output logic [2:0]     alu_operacion_o,
  input  logic [N-1:0]   alu_resultado_i,
  input  logic           alu_c_i
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;
  logic          last_step;

  assign last_step = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Start is only honoured from IDLE; DONE always lasts
  // exactly one cycle, so a start held high there is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i)   state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. In CALC, the ALU carry-out becomes the new top bit
  // and the sum shifts right into LO. As a result no product bit is lost.
  // The counter is exactly CW bits wide, so it wraps back to zero on the
  // final step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi  <= '0;
      lo  <= '0;
      m   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            m   <= multiplicand_i;
            lo  <= multiplier_i;
            hi  <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          hi  <= {alu_c_i, alu_resultado_i[N-1:1]};
          lo  <= {alu_resultado_i[0], lo[N-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and ALU drive. Operand b is gated to zero outside CALC. This
  // keeps the shared ALU quiet whenever no step is in progress.
  always_comb begin
    busy_o          = (state == CALC) || (state == DONE);
    done_o          = (state == DONE);
    product_o       = {hi, lo};
    alu_a_o         = hi;
    alu_b_o         = ((state == CALC) && lo[0]) ? m : '0;
    alu_c_o         = 1'b0;
    alu_invert_o    = 1'b0;
    alu_less_o      = 1'b0;
    alu_operacion_o = OP_ADD;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Purpose:
//   Exercises alu_mul_sequencer with N=32 against a behavioural N-bit ALU.
//   The driver pushes the expected product (plain a*b) and the expected
//   done cycle into queues. An independent monitor pops and compares these
//   whenever done_o is observed.
// ----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

  localparam int         N      = 32;
  localparam logic [2:0] OP_ADD = 3'b010;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic           alu_cin;
  logic           alu_invert;
  logic           alu_less;
  logic [2:0]     alu_op;
  logic [N-1:0]   alu_res;
  logic           alu_cout;

  int total;
  int bad;
  int cyc;

  logic [2*N-1:0] exp_prod_q[$];
  int             exp_cyc_q[$];

  alu_mul_sequencer #(.N(N), .OP_ADD(OP_ADD)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .multiplicand_i  (mcand),
    .multiplier_i    (mplier),
    .busy_o          (busy),
    .done_o          (done),
    .product_o       (product),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_c_o         (alu_cin),
    .alu_invert_o    (alu_invert),
    .alu_less_o      (alu_less),
    .alu_operacion_o (alu_op),
    .alu_resultado_i (alu_res),
    .alu_c_i         (alu_cout)
  );

  // Behavioural ALU: only the add operation produces a result.
  logic [N:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, (alu_invert ? ~alu_b : alu_b)} + {{N{1'b0}}, alu_cin};
  assign alu_res  = (alu_op == OP_ADD) ? alu_sum[N-1:0] : '0;
  assign alu_cout = (alu_op == OP_ADD) ? alu_sum[N]     : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_prod_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done_o=1 at cycle %0d expected no pulse", cyc);
      end else begin
        logic [2*N-1:0] e;
        int             ec;
        e  = exp_prod_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_output("product", product, e);
        check_output("done_latency", 64'(cyc), 64'(ec));
        check_output("busy_in_done", {63'd0, busy}, 64'd1);
        check_output("alu_ctrl", {57'd0, alu_cin, alu_invert, alu_less, alu_op}, {57'd0, 3'b000, OP_ADD});
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy_o=1 after %0d cycles expected 0", budget);
    end
  endtask

  // Issue a start while idle. The accept edge is cycle A. Done must then be
  // visible after edge A+N, which is cycle N+1 when the accept cycle is
  // counted as cycle 0.
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_done);
    @(posedge clk); #1;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk); #1;
    start  = 1'b0;
    if (expect_done) begin
      exp_prod_q.push_back(64'(a) * 64'(b));
      exp_cyc_q.push_back(cyc + N);
    end
  endtask

  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    wait_idle(N + 10);
    apply_stimulus(a, b, 1'b1);
    wait_idle(N + 10);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_output("product_hold", product, 64'(a) * 64'(b));
  endtask

  initial begin
    int n;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_done", {63'd0, done}, 64'd0);
    check_output("reset_product", product, 64'd0);
    check_output("reset_alu_b", 64'(alu_b), 64'd0);
    rst = 1'b0;

    run_mul(32'd7, 32'd6);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_output("carry_case", product, 64'hFFFF_FFFE_0000_0001);
    run_mul(32'd0, 32'h1234_5678);
    run_mul(32'h1234_5678, 32'd1);

    // Start pulses during CALC and during DONE must be ignored.
    wait_idle(N + 10);
    apply_stimulus(32'd3, 32'd4, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; mcand = 32'd9; mplier = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < N + 5) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got done_o=0 expected 1");
    end
    start = 1'b1; mcand = 32'd9; mplier = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("ignore_busy", {63'd0, busy}, 64'd0);
    check_output("ignore_product", product, 64'd12);
    repeat (4) @(posedge clk);
    #1;
    check_output("ignore_stay_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of a calculation.
    apply_stimulus(32'd100, 32'd100, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_prod_q.delete();
    exp_cyc_q.delete();
    check_output("midreset_busy", {63'd0, busy}, 64'd0);
    check_output("midreset_product", product, 64'd0);
    run_mul(32'd3, 32'd5);

    // Random operands.
    for (int i = 0; i < 12; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = $urandom();
      b = $urandom();
      if (i % 4 == 1) a = 32'($urandom_range(0, 15));
      if (i % 4 == 2) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      run_mul(a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("queue_drained", 64'(exp_prod_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
